// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and requester ids.
// Used by dmem_arbiter and rr_pick2.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  function automatic arb_state_e busy_state(input logic id);
    return (id == REQ_DBG) ? ST_BUSY1 : ST_BUSY0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker. While an owner is active,
// only the owner can be granted.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       rr_ptr,
  input  logic       owner_valid,
  input  logic       owner_id,
  output logic       grant_valid,
  output logic       grant_id
);

  logic [1:0] masked;

  always_comb begin
    masked = eligible;
    if (owner_valid) begin
      masked = eligible & ((owner_id == REQ_DBG) ? 2'b10 : 2'b01);
    end
    grant_valid = |masked;
    case (masked)
      2'b01:   grant_id = REQ_CPU;
      2'b10:   grant_id = REQ_DBG;
      2'b11:   grant_id = rr_ptr;
      default: grant_id = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Optional ownership locking is enabled with DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned S = 32,
  parameter int unsigned L = 256,
  localparam int unsigned AW = $clog2(L)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [S-1:0]  wdata0,
  input  logic [S-1:0]  wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [S-1:0]  rdata0,
  output logic [S-1:0]  rdata1,
  output logic [AW-1:0] mem_a,
  output logic [S-1:0]  mem_din,
  input  logic [S-1:0]  mem_dout,
  output logic          mem_mread,
  output logic          mem_mwrite,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  output logic          busy
);

  arb_state_e    state;
  logic          rr_ptr;
  logic          owner_valid;
  logic          owner_id;
  logic [AW-1:0] cmd_addr;
  logic [S-1:0]  cmd_wdata;
  logic          cmd_we;
  logic          cmd_lock;

  logic [1:0]    eligible;
  logic          grant_valid;
  logic          grant_id;
  logic          win_we;
  logic          win_lock;
  logic [AW-1:0] win_addr;
  logic [S-1:0]  win_wdata;
  logic          srv;

  // A requester in its ack cycle is still holding req; it must not be re-served.
  assign eligible = {req1 & ~ack1, req0 & ~ack0};

  rr_pick2 u_pick (
    .eligible    (eligible),
    .rr_ptr      (rr_ptr),
    .owner_valid (owner_valid),
    .owner_id    (owner_id),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    win_we    = we0;
    win_addr  = addr0;
    win_wdata = wdata0;
    if (grant_id == REQ_DBG) begin
      win_we    = we1;
      win_addr  = addr1;
      win_wdata = wdata1;
    end
`ifdef DMEM_ARB_LOCK_EN
    win_lock = (grant_id == REQ_DBG) ? lock1 : lock0;
`else
    win_lock = 1'b0;
`endif
  end

  assign srv     = (state == ST_BUSY1) ? REQ_DBG : REQ_CPU;
  assign mem_a   = cmd_addr;
  assign mem_din = cmd_wdata;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= 1'b0;
      owner_valid <= 1'b0;
      owner_id    <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      cmd_we      <= 1'b0;
      cmd_lock    <= 1'b0;
      mem_mread   <= 1'b0;
      mem_mwrite  <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            cmd_addr   <= win_addr;
            cmd_wdata  <= win_wdata;
            cmd_we     <= win_we;
            cmd_lock   <= win_lock;
            mem_mwrite <= win_we;
            mem_mread  <= ~win_we;
            state      <= busy_state(grant_id);
          end
        end
        ST_BUSY0, ST_BUSY1: begin
          mem_mread  <= 1'b0;
          mem_mwrite <= 1'b0;
          if (srv == REQ_DBG) begin
            ack1 <= 1'b1;
            if (!cmd_we) rdata1 <= mem_dout;
          end else begin
            ack0 <= 1'b1;
            if (!cmd_we) rdata0 <= mem_dout;
          end
          // A locked completion keeps (or takes) ownership and freezes rr_ptr.
          owner_valid <= cmd_lock;
          owner_id    <= srv;
          if (!cmd_lock) rr_ptr <= ~srv;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level memory/fairness model. Honours DMEM_ARB_LOCK_EN.
module tb_dmem_arbiter;

  localparam int unsigned S  = 32;
  localparam int unsigned L  = 256;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [S-1:0]  wdata0, wdata1;
  logic          ack0, ack1;
  logic [S-1:0]  rdata0, rdata1;
  logic [AW-1:0] mem_a;
  logic [S-1:0]  mem_din, mem_dout;
  logic          mem_mread, mem_mwrite, busy;
`ifdef DMEM_ARB_LOCK_EN
  logic          lock0, lock1;
`endif

  dmem_arbiter #(.S(S), .L(L)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .we0        (we0),
    .we1        (we1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .ack0       (ack0),
    .ack1       (ack1),
    .rdata0     (rdata0),
    .rdata1     (rdata1),
    .mem_a      (mem_a),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .mem_mread  (mem_mread),
    .mem_mwrite (mem_mwrite),
`ifdef DMEM_ARB_LOCK_EN
    .lock0      (lock0),
    .lock1      (lock1),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Memory environment: comb read, sync write, bulk preload while init_en.
  logic [S-1:0] tb_mem [L];
  logic [S-1:0] ref_mem [L];
  logic         init_en = 1'b0;
  logic [31:0]  seed = 32'h0;
  int           cyc = 0;
  int           ack0_cnt = 0, ack1_cnt = 0, mwrite_cnt = 0, busy_cnt = 0;

  function automatic logic [31:0] init_word(input int i, input logic [31:0] sd);
    if (i == 5) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ sd;
  endfunction

  assign mem_dout = tb_mem[mem_a];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (init_en) begin
      for (int i = 0; i < L; i++) tb_mem[i] <= init_word(i, seed);
    end else if (mem_mwrite) begin
      tb_mem[mem_a] <= mem_din;
    end
  end

  always @(negedge clk) begin
    if (ack0) ack0_cnt <= ack0_cnt + 1;
    if (ack1) ack1_cnt <= ack1_cnt + 1;
    if (mem_mwrite) mwrite_cnt <= mwrite_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level scoreboard state.
  logic          cur_we [2];
  logic [AW-1:0] cur_addr [2];
  logic [S-1:0]  cur_wdata [2];
  logic [S-1:0]  exp_rdata [2];
  logic [1:0]    elig_d1, elig_d2;
  logic          busy_d1;
  logic          last_served;
  int            wr_acks;
  bit            done0, done1;

  task automatic do_reset(input logic [31:0] sd);
    @(negedge clk);
    reset   = 1'b1;
    seed    = sd;
    init_en = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    init_en = 1'b0;
    reset   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; holds the request until ack, drops it after the ack cycle.
  task automatic drive_txn(input bit n, input logic we, input logic [AW-1:0] a,
                           input logic [S-1:0] d, input logic lk, output int lat);
    int start;
    bit seen;
    start = cyc;
    seen  = 1'b0;
    cur_we[n] = we; cur_addr[n] = a; cur_wdata[n] = d;
    if (n == 1'b0) begin
      we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1;
    end else begin
      we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1;
    end
`ifdef DMEM_ARB_LOCK_EN
    if (n == 1'b0) lock0 = lk; else lock1 = lk;
`else
    if (lk) $display("note: lock ignored in this build");
`endif
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (n == 1'b0) ? ack0 : ack1;
    end
    lat = cyc - start;
    check_eq(n ? "ack1_seen" : "ack0_seen", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    if (n == 1'b0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic monitor_cycle();
    logic [1:0] ackv;
    ackv = {ack1, ack0};
    check_eq("strobe_excl", 64'(mem_mread & mem_mwrite), 64'd0);
    if (ackv != 2'b00) begin
      check_eq("one_ack", 64'($countones(ackv)), 64'd1);
      for (int n = 0; n < 2; n++) begin
        if (ackv[n]) begin
          check_eq("ack_after_busy", 64'(busy_d1), 64'd1);
          check_eq("ack_idle", 64'(busy), 64'd0);
          check_eq("ack_elig", 64'(elig_d2[n]), 64'd1);
          if (elig_d2 == 2'b11) check_eq("rr_turn", 64'(n), 64'(!last_served));
          last_served = n[0];
          if (cur_we[n]) begin
            ref_mem[cur_addr[n]] = cur_wdata[n];
            wr_acks++;
          end else begin
            exp_rdata[n] = ref_mem[cur_addr[n]];
          end
          check_eq(n ? "rdata1" : "rdata0", 64'(n ? rdata1 : rdata0), 64'(exp_rdata[n]));
        end
      end
    end
    elig_d2 = elig_d1;
    elig_d1 = {req1 & ~ack1, req0 & ~ack0};
    busy_d1 = busy;
  endtask

  task automatic rand_driver(input bit n, input int count);
    int lat;
    for (int k = 0; k < count; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      drive_txn(n, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, 1'b0, lat);
    end
    if (n == 1'b0) done0 = 1'b1; else done1 = 1'b1;
  endtask

  initial begin
    int lat, a0, b0, w0;
    logic [S-1:0] saved;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
`ifdef DMEM_ARB_LOCK_EN
    lock0 = 1'b0; lock1 = 1'b0;
`endif
    #1;
    check_eq("rst_ack0", 64'(ack0), 64'd0);
    check_eq("rst_ack1", 64'(ack1), 64'd0);
    check_eq("rst_rdata0", 64'(rdata0), 64'd0);
    check_eq("rst_rdata1", 64'(rdata1), 64'd0);
    check_eq("rst_mem_a", 64'(mem_a), 64'd0);
    check_eq("rst_mem_din", 64'(mem_din), 64'd0);
    check_eq("rst_mread", 64'(mem_mread), 64'd0);
    check_eq("rst_mwrite", 64'(mem_mwrite), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    do_reset(32'h1234_0001);

    // Lone read of the preloaded word; also covers req held through its ack cycle.
    a0 = ack0_cnt; b0 = ack1_cnt; w0 = busy_cnt;
    drive_txn(1'b0, 1'b0, 8'd5, '0, 1'b0, lat);
    check_eq("t1_latency", 64'(lat), 64'd2);
    check_eq("t1_rdata0", 64'(rdata0), 64'hDEADBEEF);
    repeat (4) @(posedge clk);
    #1;
    check_eq("t1_ack0_once", 64'(ack0_cnt - a0), 64'd1);
    check_eq("t1_no_ack1", 64'(ack1_cnt - b0), 64'd0);
    check_eq("t1_busy_cycles", 64'(busy_cnt - w0), 64'd1);

    // Debug port writes, CPU reads it back.
    w0 = mwrite_cnt;
    drive_txn(1'b1, 1'b1, 8'd9, 32'h12345678, 1'b0, lat);
    check_eq("t2_mwrite_cycles", 64'(mwrite_cnt - w0), 64'd1);
    check_eq("t2_wr_rdata1", 64'(rdata1), 64'd0);
    drive_txn(1'b0, 1'b0, 8'd9, '0, 1'b0, lat);
    check_eq("t2_rdata0", 64'(rdata0), 64'h12345678);

    // Both held continuously: strict alternation, one ack every 2 cycles.
    do_reset(32'h1234_0002);
    we0 = 1'b0; addr0 = 8'd5; we1 = 1'b0; addr1 = 8'd6;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      check_eq("t3_busy", 64'(busy), 64'(i % 2));
      check_eq("t3_ack0", 64'(ack0), 64'(i % 4 == 2));
      check_eq("t3_ack1", 64'(ack1), 64'(i != 0 && i % 4 == 0));
    end
    check_eq("t3_rdata1", 64'(rdata1), 64'(init_word(6, 32'h1234_0002)));
    @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset while the debug write is in flight.
    b0 = ack1_cnt;
    saved = tb_mem[20];
    we1 = 1'b1; addr1 = 8'd20; wdata1 = ~saved; req1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("t4_busy_before", 64'(busy), 64'd1);
    check_eq("t4_mwrite_before", 64'(mem_mwrite), 64'd1);
    reset = 1'b1;
    #1;
    req1 = 1'b0;
    check_eq("t4_mwrite", 64'(mem_mwrite), 64'd0);
    check_eq("t4_busy", 64'(busy), 64'd0);
    check_eq("t4_mem_a", 64'(mem_a), 64'd0);
    check_eq("t4_mem_din", 64'(mem_din), 64'd0);
    check_eq("t4_rdata0", 64'(rdata0), 64'd0);
    @(posedge clk);
    #1;
    check_eq("t4_word_kept", 64'(tb_mem[20]), 64'(saved));
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t4_no_ack1", 64'(ack1_cnt - b0), 64'd0);

`ifdef DMEM_ARB_LOCK_EN
    begin
      int order[$];
      int l0, l1;
      do_reset(32'h1234_0003);
      fork
        begin
          drive_txn(1'b0, 1'b0, 8'd1, '0, 1'b1, l0);
          drive_txn(1'b0, 1'b0, 8'd2, '0, 1'b1, l0);
          drive_txn(1'b0, 1'b0, 8'd3, '0, 1'b0, l0);
        end
        drive_txn(1'b1, 1'b0, 8'd7, '0, 1'b0, l1);
        for (int i = 0; i < 60 && order.size() < 4; i++) begin
          @(negedge clk);
          if (ack0) order.push_back(0);
          if (ack1) order.push_back(1);
        end
      join
      check_eq("t6_ack_count", 64'(order.size()), 64'd4);
      for (int i = 0; i < order.size() && i < 4; i++) begin
        check_eq("t6_order", 64'(order[i]), 64'(i == 3));
      end
    end
`endif

    // Randomized traffic against the transaction-level model.
    do_reset(32'h5EED_0000 ^ $urandom);
    for (int i = 0; i < L; i++) ref_mem[i] = init_word(i, seed);
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    elig_d1 = '0; elig_d2 = '0; busy_d1 = 1'b0;
    last_served = 1'b1;
    wr_acks = 0; done0 = 1'b0; done1 = 1'b0;
    w0 = mwrite_cnt;
    fork
      rand_driver(1'b0, 40);
      rand_driver(1'b1, 40);
      while (!(done0 && done1)) begin
        @(negedge clk);
        monitor_cycle();
      end
    join
    repeat (2) @(posedge clk);
    #1;
    check_eq("rand_write_strobes", 64'(mwrite_cnt - w0), 64'(wr_acks));
    check_eq("rand_idle_end", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
